// File: rtl/ps2_move_tracker_if.sv
// Handshake bundle between the PS/2 receiver side and the move tracker.
// The master drives scan bytes and frame ticks; the slave returns moves and the held-key bitmap.
interface ps2_move_tracker_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       frame_tick;
    logic [2:0] move;
    logic       move_valid;
    logic [4:0] keys_held;

    modport master (
        output rx_done_tick, rx_data, frame_tick,
        input  move, move_valid, keys_held
    );

    modport slave (
        input  rx_done_tick, rx_data, frame_tick,
        output move, move_valid, keys_held
    );
endinterface

// File: rtl/ps2_move_tracker.sv
// Decodes the PS/2 set-2 byte stream into a held-key bitmap and emits at most
// one frame-aligned move per frame tick, with auto-repeat while a key stays held.
module ps2_move_tracker #(
    parameter int REPEAT_FRAMES  = 15,
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             resetn,
    ps2_move_tracker_if.slave bus
);
    localparam int RCW = (REPEAT_FRAMES > 0) ? $clog2(REPEAT_FRAMES + 1) : 1;
    localparam int TCW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
    localparam logic [RCW-1:0] REP_MAX = RCW'(REPEAT_FRAMES);
    localparam logic [TCW-1:0] TO_LAST = TCW'(PREFIX_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_t;

    state_t          r_state, w_state_nxt;
    logic [4:0]      r_keys, w_keys_nxt;
    logic [TCW-1:0]  r_to_cnt;
    logic            w_timeout;
    logic [4:0]      w_plain, w_ext;
    logic [2:0]      w_active;
    logic [2:0]      r_prev;
    logic [RCW-1:0]  r_rep, w_rep_inc;
    logic            w_repeat_hit;
    logic [2:0]      r_move;
    logic            r_move_valid;

    // Bit order matches keys_held: up, down, left, right, action
    function automatic logic [4:0] plain_key(input logic [7:0] code);
        case (code)
            8'h1D:   plain_key = 5'b00001;
            8'h1B:   plain_key = 5'b00010;
            8'h1C:   plain_key = 5'b00100;
            8'h23:   plain_key = 5'b01000;
            8'h29:   plain_key = 5'b10000;
            default: plain_key = 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] ext_key(input logic [7:0] code);
        case (code)
            8'h75:   ext_key = 5'b00001;
            8'h72:   ext_key = 5'b00010;
            8'h6B:   ext_key = 5'b00100;
            8'h74:   ext_key = 5'b01000;
            default: ext_key = 5'b00000;
        endcase
    endfunction

    assign w_plain   = plain_key(bus.rx_data);
    assign w_ext     = ext_key(bus.rx_data);
    assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_keys   <= 5'b0;
            r_to_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_keys  <= w_keys_nxt;
            if (bus.rx_done_tick || r_state == S_IDLE || w_timeout)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // E0/F0 never appear in the key maps, so OR/AND-NOT with them is a no-op
    always_comb begin
        w_state_nxt = r_state;
        w_keys_nxt  = r_keys;
        if (bus.rx_done_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.rx_data == 8'hE0)      w_state_nxt = S_EXT;
                    else if (bus.rx_data == 8'hF0) w_state_nxt = S_BRK;
                    else                           w_keys_nxt  = r_keys | w_plain;
                end
                S_EXT: begin
                    if (bus.rx_data == 8'hF0)      w_state_nxt = S_EXTBRK;
                    else if (bus.rx_data == 8'hE0) w_state_nxt = S_EXT;
                    else begin
                        w_keys_nxt  = r_keys | w_ext;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (bus.rx_data == 8'hF0)      w_state_nxt = S_BRK;
                    else if (bus.rx_data == 8'hE0) w_state_nxt = S_EXTBRK;
                    else begin
                        w_keys_nxt  = r_keys & ~w_plain;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_keys_nxt  = r_keys & ~w_ext;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        w_active = 3'd0;
        if      (r_keys[0]) w_active = 3'd1;
        else if (r_keys[1]) w_active = 3'd2;
        else if (r_keys[2]) w_active = 3'd3;
        else if (r_keys[3]) w_active = 3'd4;
        else if (r_keys[4]) w_active = 3'd5;
    end

    // Repeat counter saturates at REPEAT_FRAMES; a zero setting never re-emits
    assign w_rep_inc    = (r_rep == REP_MAX) ? r_rep : r_rep + 1'b1;
    assign w_repeat_hit = (REPEAT_FRAMES != 0) && (w_rep_inc == REP_MAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev       <= 3'd0;
            r_rep        <= '0;
            r_move       <= 3'd0;
            r_move_valid <= 1'b0;
        end else begin
            r_move_valid <= 1'b0;
            if (bus.frame_tick) begin
                r_prev <= w_active;
                if (w_active == 3'd0) begin
                    r_move <= 3'd0;
                    r_rep  <= '0;
                end else if (w_active != r_prev || w_repeat_hit) begin
                    r_move       <= w_active;
                    r_move_valid <= 1'b1;
                    r_rep        <= '0;
                end else begin
                    r_move <= 3'd0;
                    r_rep  <= w_rep_inc;
                end
            end
        end
    end

    assign bus.move       = r_move;
    assign bus.move_valid = r_move_valid;
    assign bus.keys_held  = r_keys;
endmodule

// File: tb/tb_ps2_move_tracker.sv
// Bench for ps2_move_tracker: directed scenarios plus random byte/frame traffic,
// every cycle compared against a prefix-flag behavioural model of the tracker.
module tb_ps2_move_tracker;
    localparam int REP = 15;
    localparam int PT  = 40;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    ps2_move_tracker_if bus();

    ps2_move_tracker #(.REPEAT_FRAMES(REP), .PREFIX_TIMEOUT(PT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference state: held keys, pending prefix flags, frame bookkeeping
    logic [4:0] m_keys;
    bit         m_ext, m_brk;
    int         m_idle, m_prev, m_rep;
    logic [2:0] m_move;
    logic       m_mv;

    function automatic logic [4:0] ref_map(input logic [7:0] c, input bit ext);
        logic [4:0] k;
        k = 5'b0;
        if (!ext) begin
            case (c)
                8'h1D: k = 5'b00001; 8'h1B: k = 5'b00010; 8'h1C: k = 5'b00100;
                8'h23: k = 5'b01000; 8'h29: k = 5'b10000; default: k = 5'b0;
            endcase
        end else begin
            case (c)
                8'h75: k = 5'b00001; 8'h72: k = 5'b00010; 8'h6B: k = 5'b00100;
                8'h74: k = 5'b01000; default: k = 5'b0;
            endcase
        end
        return k;
    endfunction

    task automatic m_reset();
        m_keys = 5'b0; m_ext = 0; m_brk = 0; m_idle = 0;
        m_prev = 0; m_rep = 0; m_move = 3'd0; m_mv = 1'b0;
    endtask

    task automatic model_cycle(input logic rx, input logic [7:0] d, input logic ft);
        int act;
        bit emit;
        logic [4:0] k;
        act = 0;
        emit = 0;
        if (ft) begin
            for (int i = 4; i >= 0; i--) if (m_keys[i]) act = i + 1;
            if (act == 0) m_rep = 0;
            else if (act != m_prev) begin emit = 1; m_rep = 0; end
            else begin
                m_rep = (m_rep < REP) ? m_rep + 1 : REP;
                if (REP != 0 && m_rep == REP) begin emit = 1; m_rep = 0; end
            end
            m_prev = act;
            m_move = emit ? 3'(act) : 3'd0;
            m_mv   = emit;
        end else begin
            m_mv = 1'b0;
        end
        if (rx) begin
            m_idle = 0;
            if (d == 8'hE0) begin
                if (m_ext && m_brk) begin m_ext = 0; m_brk = 0; end
                else m_ext = 1;
            end else if (d == 8'hF0) begin
                if (m_ext && m_brk) begin m_ext = 0; m_brk = 0; end
                else m_brk = 1;
            end else begin
                k = ref_map(d, m_ext);
                if (m_brk) m_keys = m_keys & ~k;
                else       m_keys = m_keys | k;
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle == PT) begin m_ext = 0; m_brk = 0; m_idle = 0; end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rx, input logic [7:0] d, input logic ft);
        bus.rx_done_tick = rx;
        bus.rx_data      = d;
        bus.frame_tick   = ft;
        @(posedge clk);
        model_cycle(rx, d, ft);
        #1;
        bus.rx_done_tick = 1'b0;
        bus.frame_tick   = 1'b0;
        chk("keys_held", 8'(bus.keys_held), 8'(m_keys));
        chk("move", 8'(bus.move), 8'(m_move));
        chk("move_valid", 8'(bus.move_valid), 8'(m_mv));
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic frame();
        step(1'b0, 8'h00, 1'b1);
    endtask

    logic [7:0] pool [12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75,
                              8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hF0};

    initial begin
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
        bus.frame_tick   = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_keys", 8'(bus.keys_held), 8'h00);
        chk("rst_move", 8'(bus.move), 8'h00);
        chk("rst_valid", 8'(bus.move_valid), 8'h00);
        resetn = 1'b1;
        idle(2);

        // 1: plain up, emit on first tick only
        send(8'h1D);
        chk("t1_keys", 8'(bus.keys_held), 8'h01);
        frame();
        chk("t1_move1", 8'(bus.move), 8'h01);
        chk("t1_valid1", 8'(bus.move_valid), 8'h01);
        idle(2); frame();
        chk("t1_move2", 8'(bus.move), 8'h00);
        idle(2); frame();
        chk("t1_valid3", 8'(bus.move_valid), 8'h00);
        send(8'hF0); send(8'h1D); frame();

        // 2: extended right held for 31 frames
        send(8'hE0); send(8'h74);
        for (int i = 0; i < 31; i++) begin
            idle(2); frame();
            chk("t2_valid", 8'(bus.move_valid), (i == 0 || i == 15 || i == 30) ? 8'h01 : 8'h00);
        end
        chk("t2_move31", 8'(bus.move), 8'h04);
        send(8'hE0); send(8'hF0); send(8'h74);
        chk("t2_keys", 8'(bus.keys_held), 8'h00);
        for (int i = 0; i < 3; i++) begin
            idle(2); frame();
            chk("t2_after", 8'(bus.move_valid), 8'h00);
        end

        // 3: priority switch and fall back to left as a new press
        send(8'h1C); frame(); idle(1);
        send(8'h1D); frame();
        chk("t3_up", 8'(bus.move), 8'h01);
        send(8'hF0); send(8'h1D); frame();
        chk("t3_left", 8'(bus.move), 8'h03);
        chk("t3_valid", 8'(bus.move_valid), 8'h01);
        send(8'hF0); send(8'h1C); frame();

        // 4: stale E0 prefix times out
        send(8'hE0); idle(PT + 5); send(8'h1B);
        chk("t4_keys", 8'(bus.keys_held), 8'h02);
        send(8'hF0); send(8'h1B); frame();

        // 5: release byte coincident with frame tick
        send(8'h1D); frame(); idle(1); frame();
        send(8'hF0);
        step(1'b1, 8'h1D, 1'b1);
        idle(2); frame();
        chk("t5_move", 8'(bus.move), 8'h00);
        chk("t5_valid", 8'(bus.move_valid), 8'h00);

        // 6: reset in the middle of an extended-break prefix
        send(8'h1D); frame(); send(8'hE0); send(8'hF0);
        @(negedge clk);
        resetn = 1'b0;
        m_reset();
        #1;
        chk("t6_keys", 8'(bus.keys_held), 8'h00);
        chk("t6_move", 8'(bus.move), 8'h00);
        @(negedge clk);
        resetn = 1'b1;
        #2;
        send(8'h75);
        chk("t6_75", 8'(bus.keys_held), 8'h00);
        frame();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic rx, ft;
            logic [7:0] d;
            int sel;
            rx  = ($urandom_range(0, 3) == 0);
            ft  = ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, 12);
            d   = (sel == 12) ? 8'($urandom) : pool[sel];
            step(rx, d, ft);
            if ($urandom_range(0, 150) == 0) idle(PT + 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
